beat_count_done_gen: RTL and testbench

Programmable beat counter that turns a stream of per-cycle valid strobes into a single-cycle 1-bit DONE pulse when a configured number of beats has been consumed. It sits directly upstream of the 1-bit single-stage pipeline register in the PE-array control path. DONE (and LAST) are the 1-bit signals that register delays to align end-of-tile with the datapath. It also exposes the live beat index for address generation.

---
 rtl/beat_count_done_gen_pkg.sv | 10 +
 rtl/beat_count_done_gen.sv | 96 +++++++++
 tb/tb_beat_count_done_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/beat_count_done_gen_pkg.sv
// Shared control definitions for the beat counter: state encoding and width.
package beat_count_done_gen_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_FIN  = 2'd2;

endpackage : beat_count_done_gen_pkg

// File: rtl/beat_count_done_gen.sv
// Programmable beat counter: counts accepted INC strobes up to a latched
// MAX_COUNT and emits a one-cycle DONE pulse after the final beat.
module beat_count_done_gen
    import beat_count_done_gen_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [COUNT_W-1:0] MAX_COUNT,
    input  logic               INC,
    input  logic               STALL,
    output logic [COUNT_W-1:0] COUNT,
    output logic               BUSY,
    output logic               LAST,
    output logic               DONE
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] max_q,   max_d;
    logic               beat_acc;
    logic               at_max;

    assign at_max   = (count_q == max_q);
    assign beat_acc = (state_q == ST_RUN) && INC && !STALL;

    // Next-state, next-count and max capture; 2'd3 falls into default -> IDLE
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        max_d   = max_q;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (START) begin
                    max_d   = MAX_COUNT;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // START and MAX_COUNT are deliberately ignored mid-run
                if (beat_acc) begin
                    if (at_max) begin
                        count_d = '0;
                        state_d = ST_FIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                count_d = '0;
                // Restart straight from FIN gives zero idle gap between runs
                if (START) begin
                    max_d   = MAX_COUNT;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat index and latched run length
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
            max_q   <= '0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    // Outputs decode straight from registers; no combinational input paths
    assign COUNT = count_q;
    assign BUSY  = (state_q == ST_RUN);
    assign DONE  = (state_q == ST_FIN);
    assign LAST  = BUSY && at_max;

endmodule : beat_count_done_gen

// File: tb/tb_beat_count_done_gen.sv
// Bench for beat_count_done_gen: run-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_beat_count_done_gen;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] MAX_COUNT = '0;
    logic         INC = 1'b0;
    logic         STALL = 1'b0;
    logic [W-1:0] COUNT;
    logic         BUSY, LAST, DONE;

    int vectors = 0;
    int miscompares = 0;

    beat_count_done_gen #(.COUNT_W(W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MAX_COUNT(MAX_COUNT),
        .INC(INC), .STALL(STALL), .COUNT(COUNT), .BUSY(BUSY),
        .LAST(LAST), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Reference: a run is "length beats long"; track beats consumed so far.
    bit m_busy = 1'b0;
    int m_taken = 0;
    int m_len = 1;
    bit m_done = 1'b0;
    bit m_fin;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_busy  = 1'b0;
            m_taken = 0;
            m_len   = 1;
            m_done  = 1'b0;
        end else begin
            m_fin = 1'b0;
            if (m_busy) begin
                if (INC && !STALL) begin
                    m_taken = m_taken + 1;
                    if (m_taken == m_len) begin
                        m_busy  = 1'b0;
                        m_taken = 0;
                        m_fin   = 1'b1;
                    end
                end
            end else if (START) begin
                m_busy  = 1'b1;
                m_taken = 0;
                m_len   = int'(MAX_COUNT) + 1;
            end
            m_done = m_fin;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        chk("model_count", int'(COUNT), m_taken);
        chk("model_busy",  int'(BUSY),  int'(m_busy));
        chk("model_last",  int'(LAST),  int'(m_busy && (m_taken == m_len - 1)));
        chk("model_done",  int'(DONE),  int'(m_done));
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        START = 1'b0; INC = 1'b0; STALL = 1'b0;
    endtask

    // Issue START for one edge with the given max; returns just after that edge
    task automatic kick(input logic [W-1:0] mx);
        START = 1'b1; MAX_COUNT = mx;
        step();
        START = 1'b0;
    endtask

    int dn;

    initial begin
        // Reset state
        repeat (2) step();
        #1;
        chk("rst_count", int'(COUNT), 0);
        chk("rst_busy",  int'(BUSY),  0);
        chk("rst_done",  int'(DONE),  0);
        RESET = 1'b1;
        step();

        // Reset mid-run: 3 beats of a 6-beat run, then async reset between edges
        kick(4'd5);
        INC = 1'b1;
        repeat (3) step();
        chk("pre_rst_count", int'(COUNT), 3);
        #3 RESET = 1'b0;
        #1;
        chk("mid_rst_count", int'(COUNT), 0);
        chk("mid_rst_busy",  int'(BUSY),  0);
        chk("mid_rst_done",  int'(DONE),  0);
        chk("mid_rst_last",  int'(LAST),  0);
        step();
        RESET = 1'b1;
        idle_inputs();
        repeat (2) step();
        chk("post_rst_idle", int'(BUSY), 0);

        // Basic run: 4 beats, INC every cycle
        kick(4'd3);
        INC = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("basic_count", int'(COUNT), i);
            chk("basic_last",  int'(LAST),  (i == 3) ? 1 : 0);
            chk("basic_done",  int'(DONE),  0);
        end
        @(negedge CLK);
        chk("basic_done_pulse", int'(DONE), 1);
        chk("basic_busy_fin",   int'(BUSY), 0);
        INC = 1'b0;
        @(negedge CLK);
        chk("basic_done_once", int'(DONE), 0);
        step();

        // Stall on alternate cycles: 3 beats in 6 INC cycles
        kick(4'd2);
        INC = 1'b1;
        for (int i = 0; i < 6; i++) begin
            STALL = (i % 2 == 0);
            step();
        end
        idle_inputs();
        @(negedge CLK);
        chk("stall_done", int'(DONE), 1);
        step();

        // Single-beat run
        kick(4'd0);
        @(negedge CLK);
        chk("single_last", int'(LAST), 1);
        chk("single_count", int'(COUNT), 0);
        INC = 1'b1;
        step();
        INC = 1'b0;
        @(negedge CLK);
        chk("single_done", int'(DONE), 1);
        step();

        // Back-to-back with START held; MAX_COUNT disturbed mid-run
        START = 1'b1; MAX_COUNT = 4'd1;
        step();
        INC = 1'b1;
        dn = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            dn += int'(DONE);
            if (i == 0) MAX_COUNT = 4'd7;
            if (i == 1) MAX_COUNT = 4'd1;
        end
        chk("b2b_done_count", dn, 3);
        idle_inputs();
        repeat (3) step();

        // Full width: 16 beats, no wrap
        kick(4'd15);
        INC = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            chk("full_count", int'(COUNT), i);
        end
        chk("full_last", int'(LAST), 1);
        @(negedge CLK);
        chk("full_done", int'(DONE), 1);
        idle_inputs();
        step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            START     = ($urandom_range(0, 3) == 0);
            INC       = ($urandom_range(0, 3) != 0);
            STALL     = ($urandom_range(0, 3) == 0);
            MAX_COUNT = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                #2 RESET = 1'b0;
                step();
                RESET = 1'b1;
            end else begin
                step();
            end
        end
        idle_inputs();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_beat_count_done_gen
